sc_max7219_rx: RTL and testbench
================================

SC_MAX7219_RX -- requirements
Module: sc_max7219_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of flip-flop synchronizer stages applied to each serial input.
REQ-002 SHALL have port SC_MAX7219_RX_CLOCK_50, input, 1 bit: the single system clock; all state is in this domain.
REQ-003 SHALL have port SC_MAX7219_RX_RESET_InLow, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port SC_MAX7219_RX_din_In, input, 1 bit: serial data, MSB first.
REQ-005 SHALL have port SC_MAX7219_RX_clk_In, input, 1 bit: serial clock; data is sampled on its rising edge.
REQ-006 SHALL have port SC_MAX7219_RX_ncs_In, input, 1 bit: load/chip select, active-low; its rising edge latches the frame.
REQ-007 SHALL have port SC_MAX7219_RX_rowAddr_In, input, 3 bits: row readout select, 0..7 maps to digit register 1..8.
REQ-008 SHALL have port SC_MAX7219_RX_rowData_Out, output, 8 bits: combinational readout of the selected digit register.
REQ-009 SHALL have port SC_MAX7219_RX_intensity_Out, output, 4 bits: intensity register.
REQ-010 SHALL have port SC_MAX7219_RX_scanLimit_Out, output, 3 bits: scan-limit register.
REQ-011 SHALL have port SC_MAX7219_RX_decode_Out, output, 8 bits: decode-mode register.
REQ-012 SHALL have port SC_MAX7219_RX_shutdownN_Out, output, 1 bit: 0 = shutdown, 1 = normal operation.
REQ-013 SHALL have port SC_MAX7219_RX_test_Out, output, 1 bit: display-test register.
REQ-014 SHALL have port SC_MAX7219_RX_frameValid_Out, output, 1 bit: one-cycle pulse when a frame is accepted.
REQ-015 SHALL have ports SC_MAX7219_RX_frameAddr_Out (output, 4 bits) and SC_MAX7219_RX_frameData_Out (output, 8 bits): contents of the last accepted frame.
REQ-016 SHALL have port SC_MAX7219_RX_frameErr_Out, output, 1 bit: one-cycle pulse when a short frame is discarded.
REQ-017 SHALL have port SC_MAX7219_RX_dout_Out, output, 1 bit: daisy-chain output equal to the bit shifted out of position 15.

Function
REQ-018 SHALL pass din, clk and ncs through SYNC_STAGES flip-flops, then detect edges by comparison with one extra registered copy.
REQ-019 SHALL operate correctly for serial clock high and low times of at least 3 CLOCK_50 cycles each.
REQ-020 SHALL implement a 16-bit shift register and a 5-bit bit counter, both updated only on a synchronized clk rise while ncs is low.
REQ-021 SHALL have states IDLE, SHIFT and LATCH: IDLE->SHIFT on ncs fall; SHIFT->LATCH on ncs rise; LATCH->IDLE after exactly one cycle.
REQ-022 SHALL, on ncs fall, clear the bit counter (the shift register is not cleared).
REQ-023 SHALL saturate the bit counter at 16; with more than 16 bits in a frame, the last 16 bits received are latched.
REQ-024 SHALL, in LATCH with count = 16, decode address bits [11:8] and data bits [7:0], ignore bits [15:12], and pulse frameValid.
REQ-025 SHALL, in LATCH with count < 16 (including 0), discard the frame, pulse frameErr and leave every register unchanged.
REQ-026 SHALL apply register writes by address: 0x1..0x8 -> digit 1..8; 0x9 -> decode; 0xA -> intensity = data[3:0]; 0xB -> scanLimit = data[2:0]; 0xC -> shutdownN = data[0]; 0xF -> test = data[0].
REQ-027 SHALL treat addresses 0x0, 0xD and 0xE as no-ops: frameValid pulses, no register changes.
REQ-028 SHALL make register updates, frameValid and frameErr visible at most SYNC_STAGES+2 CLOCK_50 cycles after the raw ncs rise.
REQ-029 SHALL update dout on the synchronized clk fall after each shift, so it follows din with a 16-bit delay.
REQ-030 SHALL ignore clk edges while ncs is high.
REQ-031 SHALL treat an ncs rise and a clk rise in the same cycle as shift first, then latch.

Reset
REQ-032 SHALL, while SC_MAX7219_RX_RESET_InLow = 0, asynchronously force: all digit registers 0x00, decode 0x00, intensity 0x0, scanLimit 0, shutdownN 0, test 0, shift register 0, counter 0, state IDLE, frameValid 0, frameErr 0, frameAddr 0, frameData 0, dout 0, synchronizers 0 (ncs synchronizer 1).
REQ-033 SHALL, if reset is released with ncs low, discard that frame by remaining in IDLE until the next ncs fall.

Structure
REQ-034 SHALL take the register-address constants (NOOP, DIGIT0..7, DECODE, INTENSITY, SCANLIMIT, SHUTDOWN, TEST) and the state encoding from the shared package, so the transmitter uses the same values.
REQ-035 SHALL contain one sub-module, sc_sync_edge (synchronizer plus rise/fall detector), instantiated three times.

Verification
REQ-036 SHALL verify: frame 0x0A05 -> intensity = 5, frameValid pulse, frameAddr = 0xA, frameData = 0x05.
REQ-037 SHALL verify: frames 0x0181 then 0x083C -> rowAddr 0 reads 0x81, rowAddr 7 reads 0x3C, other rows read 0x00.
REQ-038 SHALL verify: a 12-bit frame 0xC01 -> frameErr pulse, no frameValid, shutdownN remains 0.
REQ-039 SHALL verify: a 24-bit frame 0xFF0C01 -> shutdownN = 1, and dout replays 0xFF over the final 8 clocks.
REQ-040 SHALL verify: reset asserted after bit 9 of frame 0x0B07, then released -> scanLimit = 0, and the next full frame 0x0B07 gives scanLimit = 7.
REQ-041 SHALL verify: frame 0x0DFF -> frameValid pulses, all registers unchanged.

Source files
------------

// File: rtl/sc_max7219_rx_pkg.sv
// sc_max7219_rx_pkg: register addresses and receiver state encoding shared with the transmitter.
package sc_max7219_rx_pkg;
  localparam logic [3:0] NOOP      = 4'h0;
  localparam logic [3:0] DIGIT0    = 4'h1;
  localparam logic [3:0] DIGIT1    = 4'h2;
  localparam logic [3:0] DIGIT2    = 4'h3;
  localparam logic [3:0] DIGIT3    = 4'h4;
  localparam logic [3:0] DIGIT4    = 4'h5;
  localparam logic [3:0] DIGIT5    = 4'h6;
  localparam logic [3:0] DIGIT6    = 4'h7;
  localparam logic [3:0] DIGIT7    = 4'h8;
  localparam logic [3:0] DECODE    = 4'h9;
  localparam logic [3:0] INTENSITY = 4'hA;
  localparam logic [3:0] SCANLIMIT = 4'hB;
  localparam logic [3:0] SHUTDOWN  = 4'hC;
  localparam logic [3:0] TEST      = 4'hF;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_LATCH = 2'd2} state_t;

  function automatic logic is_digit(input logic [3:0] a);
    return (a >= DIGIT0) && (a <= DIGIT7);
  endfunction
endpackage

// File: rtl/sc_max7219_rx_sync_edge.sv
// sc_sync_edge: multi-stage synchronizer with rise/fall detection against one delayed copy.
module sc_sync_edge #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{INIT}};
      r_prev <= INIT;
    end else begin
      r_sync <= (r_sync << 1) | STAGES'(i_d);
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;
endmodule

// File: rtl/sc_max7219_rx.sv
// sc_max7219_rx: MAX7219-compatible serial receiver with register file and daisy-chain output.
module sc_max7219_rx
  import sc_max7219_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       SC_MAX7219_RX_CLOCK_50,
  input  logic       SC_MAX7219_RX_RESET_InLow,
  input  logic       SC_MAX7219_RX_din_In,
  input  logic       SC_MAX7219_RX_clk_In,
  input  logic       SC_MAX7219_RX_ncs_In,
  input  logic [2:0] SC_MAX7219_RX_rowAddr_In,
  output logic [7:0] SC_MAX7219_RX_rowData_Out,
  output logic [3:0] SC_MAX7219_RX_intensity_Out,
  output logic [2:0] SC_MAX7219_RX_scanLimit_Out,
  output logic [7:0] SC_MAX7219_RX_decode_Out,
  output logic       SC_MAX7219_RX_shutdownN_Out,
  output logic       SC_MAX7219_RX_test_Out,
  output logic       SC_MAX7219_RX_frameValid_Out,
  output logic [3:0] SC_MAX7219_RX_frameAddr_Out,
  output logic [7:0] SC_MAX7219_RX_frameData_Out,
  output logic       SC_MAX7219_RX_frameErr_Out,
  output logic       SC_MAX7219_RX_dout_Out
);
  logic w_clk, w_rst_n;
  assign w_clk   = SC_MAX7219_RX_CLOCK_50;
  assign w_rst_n = SC_MAX7219_RX_RESET_InLow;

  logic w_din, w_din_rise, w_din_fall, w_clk_q, w_clk_rise, w_clk_fall, w_ncs_q, w_ncs_rise, w_ncs_fall;
  logic w_unused;
  assign w_unused = ^{w_din_rise, w_din_fall, w_clk_q};

  sc_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_din (
    .i_clk(w_clk), .i_rst_n(w_rst_n), .i_d(SC_MAX7219_RX_din_In),
    .o_q(w_din), .o_rise(w_din_rise), .o_fall(w_din_fall));
  sc_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
    .i_clk(w_clk), .i_rst_n(w_rst_n), .i_d(SC_MAX7219_RX_clk_In),
    .o_q(w_clk_q), .o_rise(w_clk_rise), .o_fall(w_clk_fall));
  sc_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ncs (
    .i_clk(w_clk), .i_rst_n(w_rst_n), .i_d(SC_MAX7219_RX_ncs_In),
    .o_q(w_ncs_q), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall));

  state_t            r_state, w_state_nx;
  logic [15:0]       r_shift;
  logic [4:0]        r_cnt;
  logic              r_out, r_pend, r_dout, r_armed;
  logic [SYNC_STAGES:0] r_flush;
  logic              r_valid, r_err, r_shdn, r_test;
  logic [3:0]        r_faddr, r_intensity;
  logic [7:0]        r_fdata, r_decode;
  logic [2:0]        r_scan;
  logic [7:0]        r_digit [8];
  logic              w_clear, w_shift, w_latch, w_valid, w_err;
  logic [3:0]        w_addr;
  logic [7:0]        w_data;
  logic [2:0]        w_idx;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_IDLE;
    else r_state <= w_state_nx;
  end

  // A fall seen before the synchronizer has flushed and shown ncs high is a reset artifact.
  always_comb begin
    w_state_nx = (r_state == ST_IDLE)  ? ((w_ncs_fall & r_armed) ? ST_SHIFT : ST_IDLE) :
                 (r_state == ST_SHIFT) ? (w_ncs_rise ? ST_LATCH : ST_SHIFT) : ST_IDLE;
  end

  always_comb begin
    w_clear = (r_state == ST_IDLE) & w_ncs_fall & r_armed;
    w_shift = (r_state == ST_SHIFT) & w_clk_rise;
    w_latch = r_state == ST_LATCH;
    w_valid = w_latch & (r_cnt == 5'd16);
    w_err   = w_latch & (r_cnt != 5'd16);
  end

  assign w_addr = r_shift[11:8];
  assign w_data = r_shift[7:0];
  assign w_idx  = 3'(w_addr - 4'd1);

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_shift     <= '0;
      r_cnt       <= '0;
      r_out       <= 1'b0;
      r_pend      <= 1'b0;
      r_dout      <= 1'b0;
      r_armed     <= 1'b0;
      r_flush     <= '0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_faddr     <= '0;
      r_fdata     <= '0;
      r_decode    <= '0;
      r_intensity <= '0;
      r_scan      <= '0;
      r_shdn      <= 1'b0;
      r_test      <= 1'b0;
      for (int i = 0; i < 8; i++) r_digit[i] <= '0;
    end else begin
      r_flush <= {r_flush[SYNC_STAGES-1:0], 1'b1};
      r_armed <= r_armed | (r_flush[SYNC_STAGES] & w_ncs_q);
      if (w_shift) begin
        r_shift <= {r_shift[14:0], w_din};
        r_out   <= r_shift[15];
      end
      r_pend <= w_shift | (r_pend & ~w_clk_fall);
      if (w_clk_fall & r_pend) r_dout <= r_out;
      r_cnt   <= w_clear ? '0 : (w_shift && r_cnt != 5'd16) ? r_cnt + 5'd1 : r_cnt;
      r_valid <= w_valid;
      r_err   <= w_err;
      if (w_valid) begin
        r_faddr <= w_addr;
        r_fdata <= w_data;
        if (is_digit(w_addr)) r_digit[w_idx] <= w_data;
        case (w_addr)
          DECODE:    r_decode    <= w_data;
          INTENSITY: r_intensity <= w_data[3:0];
          SCANLIMIT: r_scan      <= w_data[2:0];
          SHUTDOWN:  r_shdn      <= w_data[0];
          TEST:      r_test      <= w_data[0];
          default: ;
        endcase
      end
    end
  end

  assign SC_MAX7219_RX_rowData_Out    = r_digit[SC_MAX7219_RX_rowAddr_In];
  assign SC_MAX7219_RX_intensity_Out  = r_intensity;
  assign SC_MAX7219_RX_scanLimit_Out  = r_scan;
  assign SC_MAX7219_RX_decode_Out     = r_decode;
  assign SC_MAX7219_RX_shutdownN_Out  = r_shdn;
  assign SC_MAX7219_RX_test_Out       = r_test;
  assign SC_MAX7219_RX_frameValid_Out = r_valid;
  assign SC_MAX7219_RX_frameAddr_Out  = r_faddr;
  assign SC_MAX7219_RX_frameData_Out  = r_fdata;
  assign SC_MAX7219_RX_frameErr_Out   = r_err;
  assign SC_MAX7219_RX_dout_Out       = r_dout;
endmodule

// File: tb/tb_sc_max7219_rx.sv
// tb_sc_max7219_rx: directed frames against hand-computed register contents.
module tb_sc_max7219_rx;
  logic       clk = 1'b0, rst_n, din, sclk, ncs;
  logic [2:0] row;
  logic [7:0] row_data, decode, fdata;
  logic [3:0] intensity, faddr;
  logic [2:0] scan;
  logic       shdn, test, fvalid, ferr, dout;
  int         total = 0, bad = 0, n_valid = 0, n_err = 0, p_valid, p_err;
  logic [31:0] dout_hist = '0;

  sc_max7219_rx #(.SYNC_STAGES(2)) dut (
    .SC_MAX7219_RX_CLOCK_50(clk),
    .SC_MAX7219_RX_RESET_InLow(rst_n),
    .SC_MAX7219_RX_din_In(din),
    .SC_MAX7219_RX_clk_In(sclk),
    .SC_MAX7219_RX_ncs_In(ncs),
    .SC_MAX7219_RX_rowAddr_In(row),
    .SC_MAX7219_RX_rowData_Out(row_data),
    .SC_MAX7219_RX_intensity_Out(intensity),
    .SC_MAX7219_RX_scanLimit_Out(scan),
    .SC_MAX7219_RX_decode_Out(decode),
    .SC_MAX7219_RX_shutdownN_Out(shdn),
    .SC_MAX7219_RX_test_Out(test),
    .SC_MAX7219_RX_frameValid_Out(fvalid),
    .SC_MAX7219_RX_frameAddr_Out(faddr),
    .SC_MAX7219_RX_frameData_Out(fdata),
    .SC_MAX7219_RX_frameErr_Out(ferr),
    .SC_MAX7219_RX_dout_Out(dout)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    n_valid <= n_valid + int'(fvalid);
    n_err   <= n_err + int'(ferr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic shift_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      din = v[i];
      sclk = 1'b0;
      repeat (4) @(negedge clk);
      dout_hist = {dout_hist[30:0], dout};
      sclk = 1'b1;
      repeat (4) @(negedge clk);
    end
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    dout_hist = {dout_hist[30:0], dout};
  endtask

  task automatic frame(input logic [31:0] v, input int n);
    p_valid = n_valid;
    p_err = n_err;
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(v, n);
    ncs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; din = 1'b0; sclk = 1'b0; ncs = 1'b1; row = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_row0", row_data, 8'h00);
    chk("rst_int", intensity, 4'h0);
    chk("rst_scan", scan, 3'd0);
    chk("rst_dec", decode, 8'h00);
    chk("rst_shdn", shdn, 1'b0);
    chk("rst_test", test, 1'b0);
    chk("rst_fva", {fvalid, ferr, dout}, 3'b000);
    chk("rst_frame", {faddr, fdata}, 12'h000);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // intensity frame, with the valid pulse timed against the raw ncs rise
    p_valid = n_valid;
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(32'h0A05, 16);
    ncs = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("lat_valid", fvalid, 1'b1);
    chk("lat_int", intensity, 4'h5);
    @(posedge clk);
    #1 chk("pulse_end", fvalid, 1'b0);
    repeat (6) @(negedge clk);
    chk("a05_cnt", n_valid - p_valid, 1);
    chk("a05_faddr", faddr, 4'hA);
    chk("a05_fdata", fdata, 8'h05);

    frame(32'h0181, 16);
    frame(32'h083C, 16);
    for (int r = 0; r < 8; r++) begin
      row = 3'(r);
      #1 chk($sformatf("row%0d", r), row_data, r == 0 ? 8'h81 : r == 7 ? 8'h3C : 8'h00);
    end
    row = 3'd0;

    frame(32'hC01, 12);
    chk("short_err", n_err - p_err, 1);
    chk("short_val", n_valid - p_valid, 0);
    chk("short_shdn", shdn, 1'b0);
    chk("short_faddr", faddr, 4'h8);

    frame(32'hFF0C01, 24);
    chk("long_shdn", shdn, 1'b1);
    chk("long_dout", dout_hist[7:0], 8'hFF);
    chk("long_val", n_valid - p_valid, 1);
    chk("long_frame", {faddr, fdata}, 12'hC01);

    // reset in the middle of a scan-limit frame, released while ncs is still low
    p_valid = n_valid;
    p_err = n_err;
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(32'h0B07 >> 7, 9);
    rst_n = 1'b0;
    #1 chk("mid_scan", scan, 3'd0);
    chk("mid_int", intensity, 4'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    shift_bits(32'h07, 7);
    ncs = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_val", n_valid - p_valid, 0);
    chk("mid_err", n_err - p_err, 0);
    chk("mid_scan2", scan, 3'd0);
    frame(32'h0B07, 16);
    chk("scan7", scan, 3'd7);

    frame(32'h09A5, 16);
    chk("decode", decode, 8'hA5);
    frame(32'h0F01, 16);
    chk("test", test, 1'b1);

    frame(32'h0DFF, 16);
    chk("noop_val", n_valid - p_valid, 1);
    chk("noop_frame", {faddr, fdata}, 12'hDFF);
    chk("noop_regs", {decode, intensity, scan, shdn, test}, {8'hA5, 4'h0, 3'd7, 1'b0, 1'b1});
    chk("noop_row0", row_data, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
